calc_stream_controller: RTL and testbench

- Parametrised successor to the single-lane calculator controller.
- Streams operand pairs from the two operand SRAMs over a read address range and drives them to an external ALU.
- Packs PACK ALU results into one memory word and writes that word over a write address range.
- Adds a start/busy/done/err handshake, a latched operation select, partial-word flush and a sticky overflow flag. Sits between the SRAM pair, the ALU and the top-level sequencer.

---
 rtl/calc_stream_controller_pkg.sv | 27 ++
 rtl/calc_stream_controller_if.sv | 38 +++
 rtl/calc_stream_controller_pack_buffer.sv | 39 +++
 rtl/calc_stream_controller.sv | 150 +++++++++++++++
 tb/tb_calc_stream_controller.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_stream_controller_pkg.sv
// Shared types and defaults for the calculator stream controller.
package calculator_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_OP    = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD    = 2'b00,
        OP_SUB    = 2'b01,
        OP_PASS_A = 2'b10,
        OP_PASS_B = 2'b11
    } op_t;

    // Only the arithmetic ops report carry/borrow into the sticky flag.
    function automatic logic is_arith(op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/calc_stream_controller_if.sv
// SRAM read, ALU and SRAM write signals between the controller (master) and its peers (slave).
interface calc_stream_controller_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned PACK   = 2
);
    localparam int unsigned MEM_W = DATA_W * PACK;

    logic              read_n_o;
    logic [ADDR_W-1:0] r_addr_o;
    logic [DATA_W-1:0] r_data_a_i;
    logic [DATA_W-1:0] r_data_b_i;
    logic [1:0]        op_sel_o;
    logic [DATA_W-1:0] op_a_o;
    logic [DATA_W-1:0] op_b_o;
    logic [DATA_W-1:0] alu_res_i;
    logic              alu_carry_i;
    logic              write_n_o;
    logic [ADDR_W-1:0] w_addr_o;
    logic [MEM_W-1:0]  w_data_o;

    modport master (
        output read_n_o, r_addr_o,
        input  r_data_a_i, r_data_b_i,
        output op_sel_o, op_a_o, op_b_o,
        input  alu_res_i, alu_carry_i,
        output write_n_o, w_addr_o, w_data_o
    );

    modport slave (
        input  read_n_o, r_addr_o,
        output r_data_a_i, r_data_b_i,
        input  op_sel_o, op_a_o, op_b_o,
        output alu_res_i, alu_carry_i,
        input  write_n_o, w_addr_o, w_data_o
    );

endinterface

// File: rtl/calc_stream_controller_pack_buffer.sv
// Collects PACK result lanes into one memory word; lane 0 occupies the low bits.
module calc_pack_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PACK   = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  logic                   clear_i,
    input  logic [DATA_W-1:0]      data_i,
    output logic [DATA_W*PACK-1:0] word_o,
    output logic                   last_o
);
    localparam int unsigned CNT_W = (PACK > 1) ? $clog2(PACK) : 1;

    logic [DATA_W-1:0] lanes_q [PACK];
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < PACK; i++) lanes_q[i] <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            for (int unsigned i = 0; i < PACK; i++) lanes_q[i] <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            lanes_q[cnt_q] <= data_i;
            cnt_q          <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        word_o = '0;
        for (int unsigned i = 0; i < PACK; i++) word_o[i*DATA_W +: DATA_W] = lanes_q[i];
    end

    assign last_o = (cnt_q == CNT_W'(PACK - 1));

endmodule

// File: rtl/calc_stream_controller.sv
// Streams operand pairs from SRAM through an external ALU and writes packed results back.
// Optional CALC_SAT_EN: lanes with carry/borrow store saturated values instead of the wrapped result.
module calc_stream_controller
    import calculator_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned PACK   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [ADDR_W-1:0] read_start_addr_i,
    input  logic [ADDR_W-1:0] read_end_addr_i,
    input  logic [ADDR_W-1:0] write_start_addr_i,
    input  logic [ADDR_W-1:0] write_end_addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              ovf_o,
    calc_stream_controller_if.master bus
);
    localparam int unsigned MEM_W = DATA_W * PACK;

    state_t            state_q, state_d;
    op_t               op_q;
    logic [ADDR_W-1:0] raddr_q, waddr_q, rend_q, wend_q;
    logic              reads_done_q;
    logic              ovf_q;
    logic              err_q;

    logic              ranges_ok;
    logic              accept;
    logic              pack_last;
    logic              pack_clear;
    logic [MEM_W-1:0]  packed_word;
    logic [DATA_W-1:0] lane_data;

    assign ranges_ok  = (read_end_addr_i >= read_start_addr_i) &&
                        (write_end_addr_i >= write_start_addr_i);
    assign accept     = (state_q == S_IDLE) && start_i && ranges_ok;
    assign pack_clear = accept || (state_q == S_WRITE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        busy_o        = 1'b0;
        done_o        = 1'b0;
        bus.read_n_o  = 1'b1;
        bus.write_n_o = 1'b1;
        bus.op_a_o    = '0;
        bus.op_b_o    = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_READ;
            end
            S_READ: begin
                busy_o       = 1'b1;
                bus.read_n_o = 1'b0;
                state_d      = S_OP;
            end
            S_OP: begin
                busy_o     = 1'b1;
                bus.op_a_o = bus.r_data_a_i;
                bus.op_b_o = bus.r_data_b_i;
                // Word closes on a full buffer or on the last read address.
                if (pack_last || (raddr_q == rend_q)) state_d = S_WRITE;
                else                                  state_d = S_READ;
            end
            S_WRITE: begin
                busy_o        = 1'b1;
                bus.write_n_o = 1'b0;
                if ((waddr_q == wend_q) || reads_done_q) state_d = S_DONE;
                else                                     state_d = S_READ;
            end
            S_DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lane_data = bus.alu_res_i;
`ifdef CALC_SAT_EN
        if (bus.alu_carry_i) begin
            if (op_q == OP_ADD)      lane_data = '1;
            else if (op_q == OP_SUB) lane_data = '0;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_q         <= OP_ADD;
            raddr_q      <= '0;
            waddr_q      <= '0;
            rend_q       <= '0;
            wend_q       <= '0;
            reads_done_q <= 1'b0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            err_q <= (state_q == S_IDLE) && start_i && !ranges_ok;
            if (accept) begin
                op_q         <= op_t'(op_i);
                raddr_q      <= read_start_addr_i;
                waddr_q      <= write_start_addr_i;
                rend_q       <= read_end_addr_i;
                wend_q       <= write_end_addr_i;
                reads_done_q <= 1'b0;
                ovf_q        <= 1'b0;
            end
            if (state_q == S_OP) begin
                raddr_q <= raddr_q + ADDR_W'(1);
                if (raddr_q == rend_q) reads_done_q <= 1'b1;
                if (is_arith(op_q) && bus.alu_carry_i) ovf_q <= 1'b1;
            end
            if (state_q == S_WRITE) waddr_q <= waddr_q + ADDR_W'(1);
        end
    end

    calc_pack_buffer #(
        .DATA_W (DATA_W),
        .PACK   (PACK)
    ) u_pack (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (state_q == S_OP),
        .clear_i (pack_clear),
        .data_i  (lane_data),
        .word_o  (packed_word),
        .last_o  (pack_last)
    );

    assign bus.r_addr_o = raddr_q;
    assign bus.w_addr_o = waddr_q;
    assign bus.w_data_o = packed_word;
    assign bus.op_sel_o = op_q;
    assign err_o        = err_q;
    assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_calc_stream_controller.sv
// Directed bench for calc_stream_controller with an SRAM/ALU environment and a transaction-level model.
module tb_calc_stream_controller;
    import calculator_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 10;
    localparam int unsigned PK = 2;
    localparam logic [63:0] SENT = 64'hDEAD_BEEF_DEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [1:0]    op_i;
    logic [AW-1:0] rs_i, re_i, ws_i, we_i;
    logic          busy, done, err, ovf;

    calc_stream_controller_if #(.DATA_W(DW), .ADDR_W(AW), .PACK(PK)) bus ();

    calc_stream_controller #(.DATA_W(DW), .ADDR_W(AW), .PACK(PK)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .start_i            (start_i),
        .op_i               (op_i),
        .read_start_addr_i  (rs_i),
        .read_end_addr_i    (re_i),
        .write_start_addr_i (ws_i),
        .write_end_addr_i   (we_i),
        .busy_o             (busy),
        .done_o             (done),
        .err_o              (err),
        .ovf_o              (ovf),
        .bus                (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];
    logic [63:0] wmem  [1024];
    logic        wipe;

    // External ALU: combinational from the operand bus.
    always_comb begin
        logic [32:0] sum;
        sum = '0;
        bus.alu_res_i   = '0;
        bus.alu_carry_i = 1'b0;
        case (bus.op_sel_o)
            2'b00: begin
                sum = {1'b0, bus.op_a_o} + {1'b0, bus.op_b_o};
                bus.alu_res_i   = sum[31:0];
                bus.alu_carry_i = sum[32];
            end
            2'b01: begin
                bus.alu_res_i   = bus.op_a_o - bus.op_b_o;
                bus.alu_carry_i = bus.op_a_o < bus.op_b_o;
            end
            2'b10:   bus.alu_res_i = bus.op_a_o;
            default: bus.alu_res_i = bus.op_b_o;
        endcase
    end

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            bus.r_data_a_i <= '0;
            bus.r_data_b_i <= '0;
        end else if (!bus.read_n_o) begin
            bus.r_data_a_i <= mem_a[bus.r_addr_o];
            bus.r_data_b_i <= mem_b[bus.r_addr_o];
        end
    end

    always @(posedge clk) begin
        if (wipe) begin
            for (int i = 0; i < 1024; i++) wmem[i] <= SENT;
        end else if (!bus.write_n_o) begin
            wmem[bus.w_addr_o] <= bus.w_data_o;
        end
    end

    logic [AW-1:0] q_raddr [$];
    logic [AW-1:0] q_waddr [$];
    logic [63:0]   q_wdata [$];
    logic          q_ovf   [$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of bus activity against the queued model transactions.
    task automatic compare();
        if (rst_i === 1'b1) begin
            if (bus.read_n_o === 1'b0) begin
                if (q_raddr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL read_addr: unexpected read at %0h, none expected", bus.r_addr_o);
                end else chk("read_addr", 64'(bus.r_addr_o), 64'(q_raddr.pop_front()));
            end
            if (bus.write_n_o === 1'b0) begin
                if (q_waddr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL write: unexpected write %0h at %0h, none expected", bus.w_data_o, bus.w_addr_o);
                end else begin
                    chk("write_addr", 64'(bus.w_addr_o), 64'(q_waddr.pop_front()));
                    chk("write_data", bus.w_data_o, q_wdata.pop_front());
                end
            end
            if (done === 1'b1) begin
                if (q_ovf.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done: unexpected done pulse, none expected");
                end else chk("ovf_at_done", 64'(ovf), 64'(q_ovf.pop_front()));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
    endtask

    // Transaction model: expected reads, packed writes, overflow and start-to-done latency.
    task automatic model_job(input logic [1:0] op, input int rs, input int re,
                             input int ws, input int we, output int lat);
        int nr, nw, i, words;
        logic acc_ovf;
        logic [63:0] word;
        logic [32:0] sum;
        logic [31:0] a, b, res;
        logic c;
        nr = re - rs + 1; nw = we - ws + 1; i = 0; words = 0; acc_ovf = 1'b0;
        for (int w = 0; w < nw; w++) begin
            word = '0;
            for (int l = 0; l < int'(PK) && i < nr; l++) begin
                a = mem_a[rs + i]; b = mem_b[rs + i];
                c = 1'b0;
                case (op)
                    2'b00: begin sum = {1'b0, a} + {1'b0, b}; res = sum[31:0]; c = sum[32]; end
                    2'b01: begin res = a - b; c = a < b; end
                    2'b10: res = a;
                    default: res = b;
                endcase
`ifdef CALC_SAT_EN
                if (c && op == 2'b00) res = 32'hFFFF_FFFF;
                if (c && op == 2'b01) res = 32'h0;
`endif
                word[l*32 +: 32] = res;
                if (op == 2'b00 || op == 2'b01) acc_ovf = acc_ovf | c;
                q_raddr.push_back(AW'(rs + i));
                i++;
            end
            q_waddr.push_back(AW'(ws + w));
            q_wdata.push_back(word);
            words++;
            if (i == nr) break;
        end
        q_ovf.push_back(acc_ovf);
        lat = 2 * i + words + 1;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            if (done === 1'b1) begin lat = k; break; end
            tick();
        end
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: no done within 200 cycles, expected one");
        end
    endtask

    task automatic run_job(input logic [1:0] op, input int rs, input int re,
                           input int ws, input int we, output int lat, output int exp_lat);
        model_job(op, rs, re, ws, we, exp_lat);
        op_i = op; rs_i = AW'(rs); re_i = AW'(re); ws_i = AW'(ws); we_i = AW'(we);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done(lat);
        chk("latency", 64'(lat), 64'(exp_lat));
        tick();
    endtask

    task automatic expect_err(input int rs, input int re, input int ws, input int we);
        int n_err, n_busy, n_done, n_rd, n_wr;
        rs_i = AW'(rs); re_i = AW'(re); ws_i = AW'(ws); we_i = AW'(we);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n_err = 0; n_busy = 0; n_done = 0; n_rd = 0; n_wr = 0;
        for (int i = 0; i < 6; i++) begin
            n_err  += int'(err);
            n_busy += int'(busy);
            n_done += int'(done);
            n_rd   += int'(!bus.read_n_o);
            n_wr   += int'(!bus.write_n_o);
            tick();
        end
        chk("err_pulses", 64'(n_err), 64'd1);
        chk("err_busy", 64'(n_busy), 64'd0);
        chk("err_done", 64'(n_done), 64'd0);
        chk("err_reads", 64'(n_rd), 64'd0);
        chk("err_writes", 64'(n_wr), 64'd0);
    endtask

    initial begin
        int lat, elat, n_busy;
        bit seen;
        rst_i = 1'b0; start_i = 1'b0; op_i = '0;
        rs_i = '0; re_i = '0; ws_i = '0; we_i = '0;
        wipe = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 32'(i + 1);
            mem_b[i] = 32'(10 * (i + 1));
        end
        // Overflow lanes: 0xFFFF_FFF0 + 0x20 and 5 - 7.
        mem_a[4] = 32'hFFFF_FFF0; mem_b[4] = 32'h20;
        mem_a[5] = 32'd5;         mem_b[5] = 32'd7;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_read_n", 64'(bus.read_n_o), 64'd1);
        chk("rst_write_n", 64'(bus.write_n_o), 64'd1);
        chk("rst_w_data", bus.w_data_o, 64'd0);
        wipe = 1'b0;
        rst_i = 1'b1;
        tick();

        run_job(OP_ADD, 0, 3, 16, 17, lat, elat);
        chk("t1_latency_lit", 64'(lat), 64'd11);
        chk("t1_mem16", wmem[16], 64'h0000_0016_0000_000B);
        chk("t1_mem17", wmem[17], 64'h0000_002C_0000_0021);
        chk("t1_ovf", 64'(ovf), 64'd0);

        run_job(OP_ADD, 0, 2, 16, 17, lat, elat);
        chk("t2_latency_lit", 64'(lat), 64'd9);
        chk("t2_mem17_partial", wmem[17], 64'h0000_0000_0000_0021);

        expect_err(5, 3, 16, 17);
        expect_err(0, 3, 17, 16);

        // The op is latched per run, so each overflow case is a one-lane run.
        run_job(OP_ADD, 4, 4, 20, 20, lat, elat);
        chk("t4_add_ovf", 64'(ovf), 64'd1);
        run_job(OP_SUB, 5, 5, 21, 21, lat, elat);
        chk("t4_sub_ovf", 64'(ovf), 64'd1);
`ifdef CALC_SAT_EN
        chk("t4_add_word", wmem[20], 64'h0000_0000_FFFF_FFFF);
        chk("t4_sub_word", wmem[21], 64'h0000_0000_0000_0000);
`else
        chk("t4_add_word", wmem[20], 64'h0000_0000_0000_0010);
        chk("t4_sub_word", wmem[21], 64'h0000_0000_FFFF_FFFE);
`endif

        run_job(OP_PASS_B, 0, 3, 24, 25, lat, elat);
        chk("passb_mem24", wmem[24], 64'h0000_0014_0000_000A);
        chk("passb_mem25", wmem[25], 64'h0000_0028_0000_001E);
        chk("passb_ovf_cleared", 64'(ovf), 64'd0);

        run_job(OP_ADD, 0, 3, 30, 30, lat, elat);
        chk("wshort_latency_lit", 64'(lat), 64'd6);
        chk("wshort_mem30", wmem[30], 64'h0000_0016_0000_000B);
        chk("wshort_mem31_untouched", wmem[31], SENT);

        // Reset during the first word write.
        wipe = 1'b1; tick(); wipe = 1'b0;
        model_job(OP_ADD, 0, 3, 16, 17, elat);
        op_i = OP_ADD; rs_i = 0; re_i = 3; ws_i = 16; we_i = 17;
        start_i = 1'b1; tick(); start_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (bus.write_n_o === 1'b0) begin seen = 1'b1; break; end
            tick();
        end
        chk("rst_mid_write_seen", 64'(seen), 64'd1);
        rst_i = 1'b0;
        #1;
        chk("rst_mid_write_n", 64'(bus.write_n_o), 64'd1);
        chk("rst_mid_read_n", 64'(bus.read_n_o), 64'd1);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_w_addr", 64'(bus.w_addr_o), 64'd0);
        chk("rst_mid_r_addr", 64'(bus.r_addr_o), 64'd0);
        chk("rst_mid_w_data", bus.w_data_o, 64'd0);
        q_raddr.delete(); q_waddr.delete(); q_wdata.delete(); q_ovf.delete();
        repeat (2) tick();
        chk("rst_mid_mem16", wmem[16], SENT);
        chk("rst_mid_mem17", wmem[17], SENT);
        rst_i = 1'b1;
        tick();
        run_job(OP_ADD, 0, 3, 16, 17, lat, elat);
        chk("rerun_latency_lit", 64'(lat), 64'd11);
        chk("rerun_mem16", wmem[16], 64'h0000_0016_0000_000B);
        chk("rerun_mem17", wmem[17], 64'h0000_002C_0000_0021);

        // start_i held high: back-to-back runs separated by one idle cycle.
        model_job(OP_ADD, 0, 3, 16, 17, elat);
        model_job(OP_ADD, 0, 3, 16, 17, elat);
        op_i = OP_ADD; rs_i = 0; re_i = 3; ws_i = 16; we_i = 17;
        start_i = 1'b1;
        tick();
        wait_done(lat);
        chk("held_first_latency", 64'(lat), 64'd11);
        tick();
        chk("held_idle_gap", 64'(busy), 64'd0);
        tick();
        chk("held_restart", 64'(busy), 64'd1);
        start_i = 1'b0;
        wait_done(lat);
        chk("held_second_latency", 64'(lat), 64'(elat));
        n_busy = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_busy += int'(busy);
        end
        chk("held_no_third_run", 64'(n_busy), 64'd0);
        chk("queues_drained", 64'(q_raddr.size() + q_waddr.size() + q_ovf.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
